cpu_trace_buffer: RTL

//   Parametrised retire-trace recorder for the CPU: captures {PC, instruction, ALUOut, Zero} per retired

---
 rtl/cpu_trace_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// Retire-trace recorder: captures {pc, instruction, alu_out, zero} into a circular buffer,
// stops POST_DEPTH entries after a trigger, then serves random-access readout.
module cpu_trace_buffer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned POST_DEPTH = 4,
    localparam int unsigned IDX_W     = $clog2(DEPTH),
    localparam int unsigned ENTRY_W   = ADDR_W + 32 + DATA_W + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic [1:0]         trig_mode,
    input  logic [ADDR_W-1:0]  trig_pc,
    input  logic               valid,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [31:0]        instruction,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               zero,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [1:0]         state,
    output logic [IDX_W:0]     count,
    output logic               triggered
);

    typedef enum logic [1:0] {StIdle = 2'd0, StPre = 2'd1, StPost = 2'd2, StDone = 2'd3} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]     count_q, count_d;
    logic [IDX_W-1:0]   post_cnt_q, post_cnt_d;
    logic               triggered_q, triggered_d;
    logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               we;
    logic               trig_hit;
    logic               full;
    logic [IDX_W-1:0]   base;
    logic [IDX_W-1:0]   rd_addr;

    assign full    = (count_q == (IDX_W+1)'(DEPTH));
    // Once the buffer has wrapped, the oldest surviving entry sits at the write pointer.
    assign base    = full ? wr_ptr_q : '0;
    assign rd_addr = base + rd_idx;

    always_comb begin
        case (trig_mode)
            2'b00:   trig_hit = 1'b1;
            2'b01:   trig_hit = (pc == trig_pc);
            2'b10:   trig_hit = zero;
            default: trig_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        we          = 1'b0;

        if (arm) begin
            // arm wins over a simultaneous valid: that entry is dropped
            state_d     = StPre;
            wr_ptr_d    = '0;
            count_d     = '0;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
        end else if (valid && (state_q == StPre || state_q == StPost)) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!full) begin
                count_d = count_q + 1'b1;
            end
            if (state_q == StPre) begin
                if (trig_hit) begin
                    triggered_d = 1'b1;
                    post_cnt_d  = IDX_W'(POST_DEPTH);
                    state_d     = (POST_DEPTH == 0) ? StDone : StPost;
                end
            end else begin
                post_cnt_d = post_cnt_q - 1'b1;
                if (post_cnt_q == IDX_W'(1)) begin
                    state_d = StDone;
                end
            end
        end
    end

    always_comb begin
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (rd_en && (state_q == StIdle || state_q == StDone)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = ({1'b0, rd_idx} < count_q) ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            triggered_q <= triggered_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_ptr_q] <= {pc, instruction, alu_out, zero};
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign state     = state_q;
    assign count     = count_q;
    assign triggered = triggered_q;

endmodule
